stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
- Parametrised successor to the team's 2:1 combinational mux.
- Selects one of N valid/ready input streams of width W onto a single registered output stream.
- Arbitration is round-robin or fixed-priority, chosen at runtime by a mode pin.
- Sits between multiple producers (e.g. per-channel datapaths) and one shared consumer.

Parameters:
- N, 4, number of input channels (N >= 2).
- W, 8, data width per channel in bits.
- SELW, $clog2(N), width of the channel index; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
- in_valid  input  N  per-channel valid.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel ready; one-hot or zero.
- out_valid  output  1  output word held in register.
- out_data  output  W  registered selected data.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the word when out_valid is high.

Behaviour:
- Reset (async assert, sync-safe deassert on the clk edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - Reset mid-operation discards any held word; no transfer completes in the reset cycle.
- Output register has a single stage, loaded when load_en = !out_valid || out_ready.
- Grant (combinational, evaluated every cycle):
  - mode=0: search in_valid starting at index ptr, ascending, wrapping N-1 -> 0; first valid channel wins.
  - mode=1: lowest-index valid channel wins; ptr is ignored.
  - in_ready[g]=1 only when load_en=1 and channel g is granted; all other in_ready bits are 0.
  - in_ready never depends on out_valid of another cycle, only on load_en and in_valid.
- Transfer on input i: in_valid[i] && in_ready[i] at a rising edge. At that edge:
  - out_data <= channel i data.
  - out_sel <= i.
  - out_valid <= 1.
- Output handshake: a word is consumed when out_valid && out_ready.
  - If consumed and no input transfers in the same cycle, out_valid <= 0.
  - Consume and new load in the same cycle gives full throughput: one word per cycle, latency 1 cycle input-to-output.
- Stall: out_valid=1 and out_ready=0 means load_en=0, all in_ready=0, and out_data/out_sel are held stable.
- Pointer update: on each input transfer with mode=0, ptr <= (g+1) mod N. No update when mode=1 or when no transfer occurs.
- Mode switching: mode is sampled combinationally each cycle. Switching mid-stream is legal; ptr retains its value across mode=1 periods.
- No valid inputs: no in_ready asserted and the output drains normally.
- Inputs must hold in_valid and in_data until accepted; the block does not check this.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with out_valid=1 -> out_valid, out_data, out_sel drop to 0 immediately. After release, the first grant in mode=0 goes to channel 0.
- Round-robin fairness: N=4, mode=0, all in_valid=1, out_ready=1 constantly, channel i data = 8'hA0+i -> out_sel sequence 0,1,2,3,0,… one per cycle; out_data A0,A1,A2,A3,A0.
- Fixed priority: mode=1, in_valid=4'b1010 held -> channel 1 always granted, out_data=8'hA1 every cycle; in_ready[3] is never asserted.
- Backpressure: load word from channel 2, then out_ready=0 for 3 cycles -> out_valid=1, out_data and out_sel stable, in_ready=0. On out_ready=1, the next word loads in the same cycle.
- Wrap-around skip: mode=0, ptr=3, in_valid=4'b0101 -> channel 0 granted and ptr becomes 1. The next grant goes to channel 2.
- Drain/empty: a single transfer followed by in_valid=0 with out_ready=1 -> out_valid is high for exactly 1 cycle, then 0.

Source files
------------

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream mux with runtime round-robin or fixed-priority arbitration onto one registered output.
// Latency: 1 cycle input-to-output; sustains one word per cycle when the consumer is ready.
// Backpressure: a held word with out_ready low blocks the output register, and every in_ready stays low.
module stream_mux_rr #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [N-1:0]      in_valid,
    input  logic [N*W-1:0]    in_data,
    output logic [N-1:0]      in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_sel,
    input  logic              out_ready
);

    logic            vld_q, vld_d;
    logic [W-1:0]    data_q, data_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            load_en;
    logic            gnt_vld;
    logic [SELW-1:0] gnt_idx;
    logic            xfer;

    assign load_en = !vld_q || out_ready;

    // Search starts at ptr in round-robin mode and at 0 in priority mode; the first valid channel wins.
    always_comb begin
        int              idx;
        logic [SELW-1:0] idx_s;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx = mode ? k : int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_s = SELW'(idx);
            if (!gnt_vld && in_valid[idx_s]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx_s;
            end
        end
    end

    assign xfer     = load_en && gnt_vld;
    assign in_ready = xfer ? (N'(1) << gnt_idx) : '0;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        sel_d  = sel_q;
        ptr_d  = ptr_q;
        if (xfer) begin
            vld_d  = 1'b1;
            data_d = in_data[int'(gnt_idx)*W +: W];
            sel_d  = gnt_idx;
            if (!mode) begin
                ptr_d = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + 1'b1;
            end
        end else if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            sel_q  <= '0;
            ptr_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            sel_q  <= sel_d;
            ptr_q  <= ptr_d;
        end
    end

    assign out_valid = vld_q;
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule
